// File: rtl/regfile_pkg.sv
// Shared constants and port-slicing helper for the integer register file and its users.
package regfile_pkg;

   localparam int unsigned ZERO_REG  = 0;
   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned NRD_DEF   = 2;

   // Low bit of port k's field in a flattened multi-port bus of w-bit fields.
   function automatic int unsigned port_lo(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, with per-port hazard flags.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned NRD    = NRD_DEF,
   parameter int unsigned BYPASS = 1,
   parameter int unsigned AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ISS,
   input  logic [AW-1:0]     ISS_RD,
   input  logic              WE3,
   input  logic [AW-1:0]     A3,
   input  logic [NRD*AW-1:0] RA,
   output logic [NRD-1:0]    HAZ
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;

   // Clear on writeback first so a same-cycle issue to that register wins.
   always_comb begin
      busy_nxt = busy;
      if (WE3) begin
         busy_nxt[A3] = 1'b0;
      end
      if (ISS) begin
         busy_nxt[ISS_RD] = 1'b1;
      end
      busy_nxt[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_haz
      logic [AW-1:0] ra_k;
      logic          fwd;

      assign ra_k   = RA[port_lo(k, AW) +: AW];
      assign fwd    = (BYPASS != 0) && WE3 && (A3 == ra_k);
      assign HAZ[k] = busy[ra_k] && !fwd;
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with N combinational read ports, one write port, write-to-read bypass and busy scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned NRD    = NRD_DEF,
   parameter int unsigned BYPASS = 1,
   parameter int unsigned AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   RA,
   output logic [NRD*XLEN-1:0] RD,
   output logic [NRD-1:0]      HAZ,
   input  logic                ISS,
   input  logic [AW-1:0]       ISS_RD,
   input  logic                WE3,
   input  logic [AW-1:0]       A3,
   input  logic [XLEN-1:0]     WD3
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_ok;

   assign wr_ok = WE3 && (A3 != AW'(ZERO_REG));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[A3] <= WD3;
      end
   end

   // Per-port read mux: register zero reads zero, a matching writeback is forwarded.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra_k;
      logic          fwd;

      assign ra_k = RA[port_lo(k, AW) +: AW];
      assign fwd  = (BYPASS != 0) && wr_ok && (A3 == ra_k);

      assign RD[port_lo(k, XLEN) +: XLEN] = (ra_k == AW'(ZERO_REG)) ? '0 :
                                            fwd                      ? WD3 :
                                                                       regs[ra_k];
   end

   reg_scoreboard #(
      .NREGS  (NREGS),
      .NRD    (NRD),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .ISS    (ISS),
      .ISS_RD (ISS_RD),
      .WE3    (WE3),
      .A3     (A3),
      .RA     (RA),
      .HAZ    (HAZ)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven together and checked against an array-based model.
module tb_regfile_sb;

   localparam int unsigned AWA = 5;
   localparam int unsigned XA  = 32;
   localparam int unsigned NA  = 2;
   localparam int unsigned AWC = 4;
   localparam int unsigned XC  = 64;
   localparam int unsigned NC  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NA*AWA-1:0] ra_a;
   logic [NA*XA-1:0]  rd_a, rd_b;
   logic [NA-1:0]     haz_a, haz_b;
   logic              iss, we3;
   logic [AWA-1:0]    iss_rd, a3;
   logic [XA-1:0]     wd3;
   logic [31:0]       wd_hi;
   logic [NC*AWC-1:0] ra_c;
   logic [NC*XC-1:0]  rd_c;
   logic [NC-1:0]     haz_c;
   logic [XC-1:0]     wd3_c;

   assign wd3_c = {wd_hi, wd3};

   regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .RA(ra_a), .RD(rd_a), .HAZ(haz_a),
      .ISS(iss), .ISS_RD(iss_rd), .WE3(we3), .A3(a3), .WD3(wd3));

   regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .RA(ra_a), .RD(rd_b), .HAZ(haz_b),
      .ISS(iss), .ISS_RD(iss_rd), .WE3(we3), .A3(a3), .WD3(wd3));

   regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1)) u_c (
      .clk(clk), .rst(rst), .RA(ra_c), .RD(rd_c), .HAZ(haz_c),
      .ISS(iss), .ISS_RD(iss_rd[AWC-1:0]), .WE3(we3), .A3(a3[AWC-1:0]), .WD3(wd3_c));

   // Architectural state model: register contents and busy flags per register file size.
   logic [31:0] mreg32  [32];
   bit          mbusy32 [32];
   logic [63:0] mreg16  [16];
   bit          mbusy16 [16];

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         mreg32[i]  = '0;
         mbusy32[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         mreg16[i]  = '0;
         mbusy16[i] = 1'b0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         clear_model();
      end else begin
         if (we3 && a3 != 0) begin
            mreg32[a3]  = wd3;
            mbusy32[a3] = 1'b0;
         end
         if (we3 && a3[3:0] != 0) begin
            mreg16[a3[3:0]]  = wd3_c;
            mbusy16[a3[3:0]] = 1'b0;
         end
         if (iss && iss_rd != 0)      mbusy32[iss_rd]      = 1'b1;
         if (iss && iss_rd[3:0] != 0) mbusy16[iss_rd[3:0]] = 1'b1;
      end
   end

   function automatic logic [63:0] exp_rd(int a, logic [63:0] rv, bit byp, bit we, int wa,
                                          logic [63:0] wd);
      if (a == 0) return '0;
      if (byp && we && wa == a) return wd;
      return rv;
   endfunction

   function automatic logic [63:0] exp_haz(int a, bit busy, bit byp, bit we, int wa);
      if (a == 0) return '0;
      return 64'(busy && !(byp && we && wa == a));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every falling edge: all ports of all three instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < int'(NA); k++) begin
            int a;
            a = int'(ra_a[k*AWA +: AWA]);
            chk("rd_byp1", 64'(rd_a[k*XA +: XA]),
                exp_rd(a, 64'(mreg32[a]), 1'b1, we3, int'(a3), 64'(wd3)));
            chk("haz_byp1", 64'(haz_a[k]), exp_haz(a, mbusy32[a], 1'b1, we3, int'(a3)));
            chk("rd_byp0", 64'(rd_b[k*XA +: XA]),
                exp_rd(a, 64'(mreg32[a]), 1'b0, we3, int'(a3), 64'(wd3)));
            chk("haz_byp0", 64'(haz_b[k]), exp_haz(a, mbusy32[a], 1'b0, we3, int'(a3)));
         end
         for (int k = 0; k < int'(NC); k++) begin
            int a;
            a = int'(ra_c[k*AWC +: AWC]);
            chk("rd_x64", rd_c[k*XC +: XC],
                exp_rd(a, mreg16[a], 1'b1, we3, int'(a3[3:0]), wd3_c));
            chk("haz_x64", 64'(haz_c[k]), exp_haz(a, mbusy16[a], 1'b1, we3, int'(a3[3:0])));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_model();
      iss = 1'b0; we3 = 1'b0; iss_rd = '0; a3 = '0; wd3 = '0; wd_hi = '0;
      ra_a = '0; ra_c = '0;
      chk_en = 1'b1;
      tick(); tick();

      ra_a = {5'd9, 5'd5};
      #1;
      chk("rst_rd", 64'(rd_a), 64'd0);
      chk("rst_haz", 64'({haz_a, haz_b}), 64'd0);
      rst = 1'b0;
      tick();

      // Load r5 and mark r9 busy, then reset asynchronously mid-cycle.
      we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; iss = 1'b1; iss_rd = 5'd9;
      tick();
      we3 = 1'b0; iss = 1'b0;
      #1;
      chk("wr_r5", 64'(rd_b[31:0]), 64'hDEADBEEF);
      chk("busy_r9", 64'(haz_a[1]), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_rd_a", 64'(rd_a[31:0]), 64'd0);
      chk("arst_rd_b", 64'(rd_b[31:0]), 64'd0);
      chk("arst_haz", 64'({haz_a, haz_b}), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234;
      tick();
      a3 = 5'd0; wd3 = 32'hFFFFFFFF;
      tick();
      we3 = 1'b0; ra_a = {5'd0, 5'd7};
      #1;
      chk("rd_r7", 64'(rd_b[31:0]), 64'h1234);
      chk("rd_r0", 64'(rd_b[63:32]), 64'd0);

      ra_a = {5'd3, 5'd3}; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hA5A5A5A5;
      #1;
      chk("byp_p0", 64'(rd_a[31:0]), 64'hA5A5A5A5);
      chk("byp_p1", 64'(rd_a[63:32]), 64'hA5A5A5A5);
      chk("nobyp_old", 64'(rd_b[31:0]), 64'd0);
      tick();
      we3 = 1'b0;
      #1;
      chk("nobyp_new", 64'(rd_b), {32'hA5A5A5A5, 32'hA5A5A5A5});

      iss = 1'b1; iss_rd = 5'd9; ra_a = {5'd9, 5'd9};
      #1;
      chk("iss_same_cyc", 64'(haz_a), 64'd0);
      tick();
      iss = 1'b0;
      #1;
      chk("haz_r9_a", 64'(haz_a), 64'd3);
      chk("haz_r9_b", 64'(haz_b), 64'd3);
      we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55;
      #1;
      chk("wb_haz_a", 64'(haz_a), 64'd0);
      chk("wb_rd_a", 64'(rd_a[31:0]), 64'h55);
      chk("wb_haz_b", 64'(haz_b), 64'd3);
      tick();
      we3 = 1'b0;
      #1;
      chk("wb_haz_b_next", 64'(haz_b), 64'd0);

      // Issue and writeback collide on r4: the new issue keeps it busy.
      iss = 1'b1; iss_rd = 5'd4;
      tick();
      we3 = 1'b1; a3 = 5'd4; wd3 = 32'h77;
      tick();
      iss = 1'b0; we3 = 1'b0; ra_a = {5'd0, 5'd4};
      #1;
      chk("r4_haz_a", 64'(haz_a), 64'd1);
      chk("r4_haz_b", 64'(haz_b), 64'd1);
      chk("r4_data", 64'(rd_b[31:0]), 64'h77);

      iss = 1'b1; iss_rd = 5'd0;
      tick();
      iss = 1'b0; ra_a = {5'd0, 5'd0};
      #1;
      chk("iss_r0", 64'({haz_a, haz_b}), 64'd0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            iss = 1'b0; we3 = 1'b0; rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         iss    = 1'($urandom_range(0, 1));
         iss_rd = AWA'($urandom);
         we3    = 1'($urandom_range(0, 1));
         a3     = AWA'($urandom);
         wd3    = $urandom;
         wd_hi  = $urandom;
         for (int k = 0; k < int'(NA); k++) begin
            ra_a[k*AWA +: AWA] = ($urandom_range(0, 2) == 0) ? a3 : AWA'($urandom);
         end
         for (int k = 0; k < int'(NC); k++) begin
            ra_c[k*AWC +: AWC] = ($urandom_range(0, 2) == 0) ? a3[3:0] : AWC'($urandom);
         end
         tick();
      end

      iss = 1'b0; we3 = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with N combinational read ports, one clocked write port, write-to-read bypass and a per-register busy scoreboard. It sits in the decode/writeback stages of the pipelined core. Decode reads operands and marks the destination register busy on issue. Writeback writes the result and clears the busy bit. Per-port hazard flags tell decode when an operand is not yet valid.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers, power of two, ≥2
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports and counted as hazard-free
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- RA  in  NRD*AW  read addresses; port k uses RA[k*AW +: AW]
- RD  out  NRD*XLEN  read data; port k uses RD[k*XLEN +: XLEN]
- HAZ  out  NRD  HAZ[k]=1 means operand on port k is pending (busy, not bypassed)
- ISS  in  1  issue strobe: mark ISS_RD busy
- ISS_RD  in  AW  destination of issuing instruction
- WE3  in  1  writeback enable
- A3  in  AW  writeback address
- WD3  in  XLEN  writeback data

## Operation
- Register 0 is hardwired zero:
  - writes to 0 are ignored
  - ISS with ISS_RD=0 sets nothing
  - RD for address 0 is always 0
  - HAZ for address 0 is always 0
- Read port k, combinational:
  - if BYPASS=1, WE3=1, A3=RA_k and A3≠0: RD_k = WD3
  - otherwise RD_k = REG[RA_k]
- Write: on posedge, if WE3=1 and A3≠0, REG[A3] <= WD3.
- Scoreboard: vector BUSY[NREGS-1:0]; bit 0 is constant 0. On posedge, for each r≠0:
  - if ISS=1 and ISS_RD=r: BUSY[r] <= 1, even if WE3=1 and A3=r the same cycle. The newer producer wins.
  - else if WE3=1 and A3=r: BUSY[r] <= 0
  - else hold.
- HAZ[k], combinational:
  - HAZ[k] = BUSY[RA_k] && !(BYPASS && WE3 && A3==RA_k)
  - This uses the current BUSY value; a same-cycle ISS does not affect it.
- WE3 to a register that is not busy is legal. It writes data; BUSY stays 0.
- ISS to a register that is already busy is legal; the bit stays 1. Single-outstanding-producer tracking only; the pipeline guarantees in-order writeback.
- Multiple read ports with the same address return identical data and HAZ.

## Timing
- Read latency 0: RD and HAZ are combinational from RA, BUSY, WE3/A3/WD3 and REG.
- Write latency 1: the value is visible in REG after the edge. With BYPASS=0 it is readable only in the next cycle.
- Busy set latency 1: HAZ rises in the cycle after ISS.
- Busy clear: with BYPASS=1, HAZ drops in the WE3 cycle itself; with BYPASS=0, in the cycle after.
- Reset, asynchronous on rst=1, takes effect immediately regardless of clk:
  - all REG entries = 0
  - BUSY = 0
  - therefore every RD = 0 and HAZ = 0 (with WE3=0) while rst is high
- Reset mid-operation discards pending busy bits and data. ISS/WE3 are ignored while rst=1.
- The first edge after rst deasserts performs normal updates.

## Structure
- Shared package regfile_pkg:
  - localparam ZERO_REG = 0
  - default XLEN and NREGS constants
  - function to extract port k address/data slices, for reuse by the decode stage
- Sub-module reg_scoreboard (clk, rst, ISS, ISS_RD, WE3, A3, RA, BYPASS param → HAZ) holds BUSY and the hazard logic.
- The top level holds the REG array, write logic and the bypass mux. Reads and bypass are generated per port with a generate loop.

## Test plan
- Reset:
  - Action: write 0xDEADBEEF to r5, then assert rst asynchronously mid-cycle.
  - Required: RD(r5)=0 immediately; HAZ=0 on all ports.
- Write/read and x0:
  - Action: WE3 writes 0x1234 to r7 and 0xFFFFFFFF to r0.
  - Required: next cycle RD(r7)=0x1234, RD(r0)=0.
- Bypass (BYPASS=1):
  - Action: WE3 writes 0xA5A5A5A5 to r3 while RA0=RA1=3.
  - Required: both RD=0xA5A5A5A5 in the same cycle.
  - With BYPASS=0: old value that cycle, new value the next.
- Scoreboard:
  - Action: ISS r9, next cycle read r9.
  - Required: HAZ=1.
  - Action: WE3 r9=0x55.
  - Required with BYPASS=1: HAZ=0 and RD=0x55 that cycle. Required with BYPASS=0: HAZ=0 the next cycle.
- Simultaneous ISS and WE3 to r4:
  - Action: BUSY[4] set beforehand; ISS r4 and WE3 r4 in the same cycle.
  - Required: BUSY[4] stays 1 and HAZ(r4)=1 the next cycle.
  - ISS r0 never raises HAZ.
- Parameter sweep:
  - Configurations: NREGS=16, NRD=3, XLEN=64.
  - Required: random writes/reads match a reference model, and HAZ matches the model's busy vector.
